cdc_hs_sender: RTL and testbench

CDC_HS_SENDER -- requirements
Module: cdc_hs_sender

---
 rtl/cdc_hs_sender_if.sv | 21 ++
 rtl/cdc_hs_sender.sv | 101 ++++++++++
 tb/tb_cdc_hs_sender.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_hs_sender_if.sv
// Source-side valid/ready payload bundle feeding the CDC handshake sender.
// The master drives a payload; the slave (the sender) reports when it can take one.
interface cdc_hs_sender_if #(
  parameter int DW = 32
);
  logic          src_vld;
  logic          src_rdy;
  logic [DW-1:0] src_data;

  modport master (
    output src_vld,
    output src_data,
    input  src_rdy
  );

  modport slave (
    input  src_vld,
    input  src_data,
    output src_rdy
  );
endinterface

// File: rtl/cdc_hs_sender.sv
// Toggle-handshake sender: latches a payload, flips req_out, and waits for the
// far domain's synchronized ack toggle to match before accepting another payload.
module cdc_hs_sender #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 16
) (
  input  logic                clk,
  input  logic                rst,
  cdc_hs_sender_if.slave      src,
  output logic                req_out,
  output logic [DW-1:0]       data_out,
  input  logic                ack_in,
  output logic                done,
  output logic [CW-1:0]       xfer_cnt,
  output logic                proto_err
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_q, req_d;
  logic [DW-1:0]          data_q, data_d;
  logic                   done_q, done_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   perr_q, perr_d;
  logic                   ack_s;
  logic                   rdy;
  logic                   accept;

  // ack_in is asynchronous, so only the first sync flop ever looks at it.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], ack_in};
  assign ack_s  = sync_q[SYNC_STAGES-1];

  assign rdy    = (state_q == IDLE) && !rst;
  assign accept = rdy && src.src_vld;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        // A mismatch here means the far side toggled ack with nothing in flight.
        if (ack_s != req_q) begin
          perr_d = 1'b1;
        end
        if (accept) begin
          data_d  = src.src_data;
          req_d   = ~req_q;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == req_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

  assign src.src_rdy = rdy;
  assign req_out     = req_q;
  assign data_out    = data_q;
  assign done        = done_q;
  assign xfer_cnt    = cnt_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_cdc_hs_sender.sv
// Randomized self-checking bench for cdc_hs_sender; the far-domain receiver is
// played by the bench, and expectations come from counts of accepts and completions.
module tb_cdc_hs_sender;

  localparam int DW   = 32;
  localparam int SYNC = 2;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqOut;
  logic [DW-1:0] dataOut;
  logic          ackIn;
  logic          done;
  logic [CW-1:0] xferCnt;
  logic          protoErr;

  cdc_hs_sender_if #(.DW(DW)) srcIf ();

  cdc_hs_sender #(
    .DW(DW),
    .SYNC_STAGES(SYNC),
    .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src(srcIf),
    .req_out(reqOut),
    .data_out(dataOut),
    .ack_in(ackIn),
    .done(done),
    .xfer_cnt(xferCnt),
    .proto_err(protoErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int completes = 0;
  int totalDone = 0;
  int doneSeen = 0;
  logic [DW-1:0] expData = '0;

  // Counts every done pulse actually seen, independent of the stimulus code.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) doneSeen++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic expReq();
    return accepts[0];
  endfunction

  function automatic logic [63:0] expCnt();
    return 64'(completes % (1 << CW));
  endfunction

  task automatic waitReady();
    int guard = 0;
    while (srcIf.src_rdy !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rdyWait", 64'(guard < 20), 64'(1));
  endtask

  task automatic expectDone();
    @(negedge clk);
    completes++;
    totalDone++;
    checkOutput("donePulse", 64'(done), 64'(1));
    checkOutput("rdyAfterDone", 64'(srcIf.src_rdy), 64'(1));
    checkOutput("xferCnt", 64'(xferCnt), expCnt());
    checkOutput("dataHeld", 64'(dataOut), 64'(expData));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    ackIn = 1'b0;
    srcIf.src_vld = 1'b0;
    srcIf.src_data = '0;
    accepts = 0;
    completes = 0;
    #1;
    checkOutput("rstRdy", 64'(srcIf.src_rdy), 64'(0));
    checkOutput("rstReq", 64'(reqOut), 64'(0));
    checkOutput("rstData", 64'(dataOut), 64'(0));
    checkOutput("rstDone", 64'(done), 64'(0));
    checkOutput("rstCnt", 64'(xferCnt), 64'(0));
    checkOutput("rstPerr", 64'(protoErr), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rdyAfterRst", 64'(srcIf.src_rdy), 64'(1));
  endtask

  // One full transfer; the receiver answers ackDelay cycles after seeing the request.
  task automatic applyStimulus(input logic [DW-1:0] data, input int ackDelay);
    waitReady();
    srcIf.src_vld = 1'b1;
    srcIf.src_data = data;
    @(negedge clk);
    accepts++;
    expData = data;
    srcIf.src_vld = 1'b0;
    srcIf.src_data = $urandom;
    checkOutput("reqToggle", 64'(reqOut), 64'(expReq()));
    checkOutput("dataLatch", 64'(dataOut), 64'(expData));
    checkOutput("rdyBusy", 64'(srcIf.src_rdy), 64'(0));
    if (ackIn == expReq()) begin
      expectDone();
    end else begin
      for (int i = 0; i < ackDelay; i++) begin
        @(negedge clk);
        checkOutput("waitData", 64'(dataOut), 64'(expData));
        checkOutput("waitReq", 64'(reqOut), 64'(expReq()));
      end
      ackIn = expReq();
      for (int i = 0; i < SYNC; i++) begin
        @(negedge clk);
        checkOutput("doneEarly", 64'(done), 64'(0));
        checkOutput("rdyEarly", 64'(srcIf.src_rdy), 64'(0));
      end
      expectDone();
    end
    @(negedge clk);
    checkOutput("doneOneCycle", 64'(done), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    ackIn = 1'b0;
    srcIf.src_vld = 1'b0;
    srcIf.src_data = '0;
    doReset();

    // Single transfer with the ack returned immediately.
    applyStimulus(32'hA5A5_0001, 0);
    checkOutput("singleCnt", 64'(xferCnt), 64'(1));

    // Stall: a new payload waits with valid held high during WAIT_ACK.
    waitReady();
    srcIf.src_vld = 1'b1;
    srcIf.src_data = 32'hCAFE_0002;
    @(negedge clk);
    accepts++;
    expData = 32'hCAFE_0002;
    srcIf.src_data = 32'h0000_1234;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("stallData", 64'(dataOut), 64'(expData));
      checkOutput("stallReq", 64'(reqOut), 64'(expReq()));
      checkOutput("stallRdy", 64'(srcIf.src_rdy), 64'(0));
    end
    ackIn = expReq();
    repeat (SYNC) @(negedge clk);
    expectDone();
    @(negedge clk);
    accepts++;
    expData = 32'h0000_1234;
    srcIf.src_vld = 1'b0;
    checkOutput("stallAccept", 64'(dataOut), 64'(32'h0000_1234));
    checkOutput("stallReq2", 64'(reqOut), 64'(expReq()));
    checkOutput("stallDoneLow", 64'(done), 64'(0));
    ackIn = expReq();
    repeat (SYNC) @(negedge clk);
    expectDone();
    @(negedge clk);

    // Random stream of 10 transfers, then 7 more to wrap the 4-bit counter.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus($urandom, int'($urandom_range(7, 0)));
    checkOutput("streamCnt", 64'(xferCnt), 64'(10));
    checkOutput("streamReq", 64'(reqOut), 64'(0));
    checkOutput("streamPerr", 64'(protoErr), 64'(0));
    for (int i = 0; i < 7; i++) applyStimulus($urandom, int'($urandom_range(7, 0)));
    checkOutput("wrapCnt", 64'(xferCnt), 64'(1));
    #1;
    checkOutput("doneCount", 64'(doneSeen), 64'(totalDone));

    // Spurious ack toggle while idle.
    ackIn = ~expReq();
    for (int i = 0; i < SYNC; i++) begin
      @(negedge clk);
      checkOutput("perrEarly", 64'(protoErr), 64'(0));
    end
    @(negedge clk);
    checkOutput("perrSet", 64'(protoErr), 64'(1));
    checkOutput("perrRdy", 64'(srcIf.src_rdy), 64'(1));
    repeat (5) @(negedge clk);
    checkOutput("perrHeld", 64'(protoErr), 64'(1));
    applyStimulus(32'h5555_AAAA, 3);
    checkOutput("perrSticky", 64'(protoErr), 64'(1));
    checkOutput("perrCnt", 64'(xferCnt), expCnt());

    // Reset in the middle of a transfer, with an ack glitch inside reset.
    waitReady();
    srcIf.src_vld = 1'b1;
    srcIf.src_data = 32'hDEAD_BEEF;
    @(negedge clk);
    accepts++;
    srcIf.src_vld = 1'b0;
    checkOutput("midReq", 64'(reqOut), 64'(expReq()));
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstReq", 64'(reqOut), 64'(0));
    checkOutput("midRstData", 64'(dataOut), 64'(0));
    checkOutput("midRstRdy", 64'(srcIf.src_rdy), 64'(0));
    checkOutput("midRstPerr", 64'(protoErr), 64'(0));
    accepts = 0;
    completes = 0;
    @(negedge clk);
    ackIn = ~ackIn;
    @(negedge clk);
    ackIn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRdyAfter", 64'(srcIf.src_rdy), 64'(1));
    repeat (SYNC + 2) @(negedge clk);
    checkOutput("midNoPerr", 64'(protoErr), 64'(0));
    checkOutput("midCnt", 64'(xferCnt), 64'(0));
    #1;
    checkOutput("midNoDone", 64'(doneSeen), 64'(totalDone));
    applyStimulus(32'h0BAD_F00D, 1);
    checkOutput("recoverCnt", 64'(xferCnt), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
